// File: rtl/d_sraml2axi_pkg.sv
// Shared definitions for the sram-like to AXI4 bridges: FSM states,
// sram-like size codes and the AXI constants tied off at the integrating top.
package d_sraml2axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/d_sraml2axi_wstrb_gen.sv
// Combinational byte-strobe decoder: sram-like size + addr[1:0] -> AXI wstrb.
// Size code 3 is not a legal sram-like size and decodes like a word access.
module sraml_wstrb_gen
  import d_sraml2axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  // One lane enable per byte lane of the 32-bit data bus.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign wstrb[gi] = (size == SZ_BYTE) ? (addr_lo == LANE) :
                       (size == SZ_HALF) ? (addr_lo[1] == LANE[1]) :
                                           1'b1;
  end

endmodule

// File: rtl/d_sraml2axi.sv
// Data-side sram-like to AXI4 bridge. Single-beat, one transaction in flight.
// AXI valids are decoded from the state register, so they are glitch-free,
// never drop before their handshake, and clear immediately on reset.
module d_sraml2axi
  import d_sraml2axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [1:0]          size_reg, size_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg, w_done_next;
  logic                aw_fin, w_fin;

  // State and latched-request registers; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      size_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      size_reg    <= size_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  // AW and W may finish in either order or together; a channel counts as
  // finished if it already handshook or is handshaking this cycle.
  assign aw_fin = aw_done_reg | awready;
  assign w_fin  = w_done_reg | wready;

  // Next-state logic and per-state handshake outputs.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    size_next    = size_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state_reg)
      IDLE: begin
        data_addr_ok = data_req;
        if (data_req) begin
          addr_next    = data_addr;
          size_next    = data_size;
          wdata_next   = data_wdata;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = data_wr ? WR_AW_W : RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_next = rdata;
          state_next = DONE;
        end
      end
      WR_AW_W: begin
        awvalid      = ~aw_done_reg;
        wvalid       = ~w_done_reg;
        aw_done_next = aw_fin;
        w_done_next  = w_fin;
        if (aw_fin && w_fin) state_next = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) state_next = DONE;
      end
      DONE: begin
        data_data_ok = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign araddr     = addr_reg;
  assign awaddr     = addr_reg;
  assign arsize     = {1'b0, size_reg};
  assign awsize     = {1'b0, size_reg};
  assign wdata      = wdata_reg;
  assign data_rdata = rdata_reg;

  sraml_wstrb_gen u_wstrb (
    .size    (size_reg),
    .addr_lo (addr_reg[1:0]),
    .wstrb   (wstrb)
  );

endmodule

// File: tb/tb_d_sraml2axi.sv
// Directed bench for d_sraml2axi: table of sram-like requests with per-channel
// AXI slave delays and hand-computed latency/strobe/read-data expectations,
// plus a hand-written mid-transaction reset sequence.
module tb_d_sraml2axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_sraml2axi #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    bit          hold;
    logic [3:0]  exp_wstrb;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Runs one request starting at a negedge with the DUT idle; acts as the
  // AXI slave, driving readies/valids at negedges after the programmed delays.
  task automatic run_txn(input vec_t v, input int idx);
    int lat, wait_cnt;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    int ar_hs, r_hs, aw_hs, w_hs, b_hs, extra_ok;
    bit done, bad;
    logic [3:0] seen_wstrb;
    logic [2:0] exp_sz;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; extra_ok = 0;
    done = 1'b0; bad = 1'b0; seen_wstrb = 4'h0;
    exp_sz = {1'b0, v.size};
    data_req = 1'b1; data_wr = v.wr; data_size = v.size;
    data_addr = v.addr; data_wdata = v.wd;
    #1;
    wait_cnt = 0;
    while (!data_addr_ok && wait_cnt < 20) begin
      @(negedge clk); #1; wait_cnt++;
    end
    chk($sformatf("v%0d addr_ok", idx), {31'b0, data_addr_ok}, 32'd1);
    if (!data_addr_ok) begin
      data_req = 1'b0;
      return;
    end
    @(negedge clk);
    if (!v.hold) data_req = 1'b0;
    lat = 1;
    while (!done && lat <= 40) begin
      if (data_addr_ok) extra_ok++;
      if (data_data_ok) begin
        done = 1'b1;
      end else begin
        if (arvalid) begin
          if (araddr !== v.addr || arsize !== exp_sz) bad = 1'b1;
          arready = (ar_cnt >= v.ar_dly); ar_cnt++;
          if (arready) ar_hs++;
        end else arready = 1'b0;
        if (rready) begin
          rvalid = (r_cnt >= v.r_dly); r_cnt++;
          rdata = rvalid ? v.rd : 32'h0BAD_0BAD;
          if (rvalid) r_hs++;
        end else rvalid = 1'b0;
        if (awvalid) begin
          if (awaddr !== v.addr || awsize !== exp_sz) bad = 1'b1;
          awready = (aw_cnt >= v.aw_dly); aw_cnt++;
          if (awready) aw_hs++;
        end else awready = 1'b0;
        if (wvalid) begin
          if (wdata !== v.wd) bad = 1'b1;
          seen_wstrb = wstrb;
          wready = (w_cnt >= v.w_dly); w_cnt++;
          if (wready) w_hs++;
        end else wready = 1'b0;
        if (bready) begin
          bvalid = (b_cnt >= v.b_dly); b_cnt++;
          if (bvalid) b_hs++;
        end else bvalid = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    data_req = 1'b0;
    chk($sformatf("v%0d data_ok seen", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d data_rdata", idx), data_rdata, v.exp_rdata);
    chk($sformatf("v%0d addr/size/data stable", idx), {31'b0, bad}, 32'd0);
    chk($sformatf("v%0d extra addr_ok", idx), extra_ok, 0);
    if (v.wr) begin
      chk($sformatf("v%0d handshakes aw/w/b/ar/r", idx),
          {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0], r_hs[3:0]}, 32'h11100);
      chk($sformatf("v%0d wstrb", idx), {28'b0, seen_wstrb}, {28'b0, v.exp_wstrb});
    end else begin
      chk($sformatf("v%0d handshakes aw/w/b/ar/r", idx),
          {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0], r_hs[3:0]}, 32'h00011);
    end
    @(negedge clk);
    chk($sformatf("v%0d data_ok one cycle", idx), {31'b0, data_data_ok}, 32'd0);
    chk($sformatf("v%0d data_rdata held", idx), data_rdata, v.exp_rdata);
    $display("txn %0d wr=%0b size=%0d addr=0x%08h lat=%0d rdata=0x%08h",
             idx, v.wr, v.size, v.addr, lat, data_rdata);
  endtask

  initial begin
    // wr size addr wdata rd ar r aw w b hold wstrb lat rdata
    vecs[0]  = '{1'b0, 2'd2, 32'h1000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0, 1'b0, 4'h0,    3, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 2'd0, 32'h2003, 32'h000000AA, 32'h0,        0, 0, 0, 0, 0, 1'b0, 4'b1000, 3, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'd2, 32'h3000, 32'h11223344, 32'h0,        0, 0, 3, 0, 1, 1'b0, 4'b1111, 7, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 2'd1, 32'h3002, 32'h55660000, 32'h0,        0, 0, 0, 2, 0, 1'b0, 4'b1100, 5, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 2'd2, 32'h3004, 32'h778899AA, 32'h0,        0, 0, 2, 2, 0, 1'b0, 4'b1111, 5, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 2'd2, 32'h4004, 32'h0,        32'h12345678, 5, 0, 0, 0, 0, 1'b1, 4'h0,    8, 32'h12345678};
    vecs[6]  = '{1'b1, 2'd1, 32'h2002, 32'hBEEF0000, 32'h0,        0, 0, 0, 0, 0, 1'b0, 4'b1100, 3, 32'h12345678};
    vecs[7]  = '{1'b0, 2'd2, 32'h5000, 32'h0,        32'hCAFEF00D, 0, 0, 0, 0, 0, 1'b0, 4'h0,    3, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 2'd0, 32'h2001, 32'h0000CC00, 32'h0,        0, 0, 0, 0, 0, 1'b0, 4'b0010, 3, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 2'd3, 32'h2000, 32'hA5A5A5A5, 32'h0,        0, 0, 0, 0, 0, 1'b0, 4'b1111, 3, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 2'd1, 32'h6002, 32'h0,        32'h0000BEEF, 0, 2, 0, 0, 0, 1'b0, 4'h0,    5, 32'h0000BEEF};
    vecs[11] = '{1'b0, 2'd0, 32'h7001, 32'h0,        32'h000000AB, 0, 0, 0, 0, 0, 1'b0, 4'h0,    3, 32'h000000AB};

    rst = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset valids ar/r/aw/w/b", {27'b0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("reset data_ok/addr_ok", {30'b0, data_data_ok, data_addr_ok}, 32'd0);
    chk("reset data_rdata", data_rdata, 32'd0);
    chk("reset latched addr", araddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

    // Abort a write while it waits in WR_B: reset mid-cycle, away from any edge.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h7000; data_wdata = 32'h0000_0001;
    #1;
    chk("rst seq addr_ok", {31'b0, data_addr_ok}, 32'd1);
    @(negedge clk);
    data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("rst seq in WR_B bready", {31'b0, bready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst async aw/w/b valids", {29'b0, awvalid, wvalid, bready}, 32'd0);
    chk("rst async ar/r/data_ok", {29'b0, arvalid, rready, data_data_ok}, 32'd0);
    chk("rst async data_rdata", data_rdata, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("txn rst abort in WR_B done");
    run_txn(vecs[11], 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
